// File: rtl/soc_event_sender.sv
// soc_event_sender: collects single-cycle event pulses from NB_EVENTS sources,
// keeps one pending bit per source, picks one pending source per cycle in
// round-robin order and queues its index in a small first-word-fall-through
// FIFO towards an event consumer.
// Optional feature: define SOC_EVENT_SENDER_LOSS_CNT_EN to add a 16-bit
// saturating lost-event counter (lost_cnt_o) with a clear input (lost_cnt_clr_i).
module soc_event_sender #(
  parameter int NB_EVENTS      = 32,
  parameter int EVENT_ID_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_EVENTS-1:0]      events_i,
  output logic                      event_fifo_valid_o,
  output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
  input  logic                      event_fifo_ready_i,
  output logic [NB_EVENTS-1:0]      event_lost_o,
`ifdef SOC_EVENT_SENDER_LOSS_CNT_EN
  output logic [15:0]               lost_cnt_o,
  input  logic                      lost_cnt_clr_i,
`endif
  output logic                      busy_o
);

  localparam int IDX_W = $clog2(NB_EVENTS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NB_EVENTS-1:0]      pending_q, pending_d;
  logic [NB_EVENTS-1:0]      lost_q, lost_d;
  logic [IDX_W-1:0]          start_q, start_d;   // index where the next search begins
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [EVENT_ID_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W:0]   cand;
  logic             fifo_full;
  logic             push;
  logic             pop;

  // Round-robin search: first pending source at or after start_q, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NB_EVENTS; i++) begin
      cand = {1'b0, start_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NB_EVENTS)) begin
        cand = cand - (IDX_W+1)'(NB_EVENTS);
      end
      if (!grant_valid && pending_q[cand[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state: push/pop decisions, pending/loss bookkeeping, FIFO pointers.
  always_comb begin
    pop       = (count_q != '0) && event_fifo_ready_i;
    fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push      = grant_valid && (!fifo_full || pop);

    pending_d = pending_q | events_i;
    lost_d    = events_i & pending_q;
    start_d   = start_q;
    if (push) begin
      // A fresh pulse on the granted source is kept as a new pending event.
      pending_d[grant_idx] = events_i[grant_idx];
      lost_d[grant_idx]    = 1'b0;
      start_d = (grant_idx == IDX_W'(NB_EVENTS - 1)) ? '0 : grant_idx + 1'b1;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers with synchronous reset; reset discards everything queued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      lost_q    <= '0;
      start_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      lost_q    <= lost_d;
      start_q   <= start_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; contents need no reset because the count gates the output.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= EVENT_ID_WIDTH'(grant_idx);
    end
  end

  // Outputs: head is forced to zero while empty so reset/idle data reads 0.
  always_comb begin
    event_fifo_valid_o = (count_q != '0);
    event_fifo_data_o  = event_fifo_valid_o ? mem_q[rd_ptr_q] : '0;
    event_lost_o       = lost_q;
    busy_o             = (|pending_q) || event_fifo_valid_o;
  end

`ifdef SOC_EVENT_SENDER_LOSS_CNT_EN
  logic [15:0] lost_cnt_q, lost_cnt_d;

  // Saturating count of cycles with any loss pulse; clear wins over increment.
  always_comb begin
    lost_cnt_d = lost_cnt_q;
    if (lost_cnt_clr_i) begin
      lost_cnt_d = '0;
    end else if ((|lost_q) && (lost_cnt_q != 16'hFFFF)) begin
      lost_cnt_d = lost_cnt_q + 16'd1;
    end
  end

  // Loss counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lost_cnt_q <= '0;
    end else begin
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign lost_cnt_o = lost_cnt_q;
`endif

endmodule

// File: tb/tb_soc_event_sender.sv
// Testbench for soc_event_sender: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_soc_event_sender;

  localparam int NB    = 32;
  localparam int EW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [NB-1:0] events_i = '0;
  logic          ready_i = 1'b0;
  logic          valid_o;
  logic [EW-1:0] data_o;
  logic [NB-1:0] lost_o;
  logic          busy_o;
`ifdef SOC_EVENT_SENDER_LOSS_CNT_EN
  logic [15:0]   lost_cnt_o;
  logic          lost_cnt_clr_i = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [NB-1:0] pend_m;
  logic [NB-1:0] lost_m;
  int            rr_m;
  int            cnt_m;
  int            q_m[$];

  soc_event_sender #(.NB_EVENTS(NB), .EVENT_ID_WIDTH(EW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .events_i           (events_i),
    .event_fifo_valid_o (valid_o),
    .event_fifo_data_o  (data_o),
    .event_fifo_ready_i (ready_i),
    .event_lost_o       (lost_o),
`ifdef SOC_EVENT_SENDER_LOSS_CNT_EN
    .lost_cnt_o         (lost_cnt_o),
    .lost_cnt_clr_i     (lost_cnt_clr_i),
`endif
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: one clock edge computed from the rules, using a queue for the FIFO.
  task automatic model_step(input logic [NB-1:0] ev, input logic rdy, input logic rst, input logic clr);
    int  g;
    bit  found;
    bit  pop;
    bit  push;
    logic [NB-1:0] nl;
    if (rst) begin
      pend_m = '0;
      lost_m = '0;
      rr_m   = 0;
      cnt_m  = 0;
      q_m.delete();
    end else begin
      pop   = (q_m.size() > 0) && rdy;
      found = 1'b0;
      g     = 0;
      for (int i = 0; i < NB; i++) begin
        if (!found && pend_m[(rr_m + i) % NB]) begin
          found = 1'b1;
          g     = (rr_m + i) % NB;
        end
      end
      push = found && ((q_m.size() < DEPTH) || pop);
      if (clr) cnt_m = 0;
      else if ((lost_m != '0) && (cnt_m < 65535)) cnt_m++;
      nl = ev & pend_m;
      if (push) nl[g] = 1'b0;
      lost_m = nl;
      if (pop) void'(q_m.pop_front());
      if (push) begin
        q_m.push_back(g);
        pend_m[g] = 1'b0;
        rr_m = (g + 1) % NB;
      end
      pend_m = pend_m | ev;
    end
  endtask

  // One clock cycle: drive inputs, advance model, sample DUT after the edge.
  task automatic tick(input logic [NB-1:0] ev, input logic rdy, input logic rst, input logic clr);
    events_i = ev;
    ready_i  = rdy;
    rst_i    = rst;
`ifdef SOC_EVENT_SENDER_LOSS_CNT_EN
    lost_cnt_clr_i = clr;
`endif
    model_step(ev, rdy, rst, clr);
    @(posedge clk);
    #1;
    check("valid", {31'd0, valid_o}, {31'd0, q_m.size() > 0});
    check("data", {24'd0, data_o}, (q_m.size() > 0) ? q_m[0] : 32'd0);
    check("lost", lost_o, lost_m);
    check("busy", {31'd0, busy_o}, {31'd0, (pend_m != '0) || (q_m.size() > 0)});
`ifdef SOC_EVENT_SENDER_LOSS_CNT_EN
    check("lost_cnt", {16'd0, lost_cnt_o}, cnt_m);
`endif
  endtask

  initial begin
    logic [NB-1:0] ev;
    pend_m = '0;
    lost_m = '0;
    rr_m   = 0;
    cnt_m  = 0;

    // Reset state
    repeat (3) tick('0, 1'b0, 1'b1, 1'b0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_lost", lost_o, 32'd0);

    // Single pulse on source 5: valid two cycles later with ID 5, then idle
    repeat (6) tick('0, 1'b1, 1'b0, 1'b0);
    tick(32'h0000_0020, 1'b1, 1'b0, 1'b0);
    check("lat_n1_valid", {31'd0, valid_o}, 32'd0);
    tick('0, 1'b1, 1'b0, 1'b0);
    check("lat_n2_valid", {31'd0, valid_o}, 32'd1);
    check("lat_n2_data", {24'd0, data_o}, 32'd5);
    tick('0, 1'b1, 1'b0, 1'b0);
    check("lat_n3_busy", {31'd0, busy_o}, 32'd0);

    // Sources 0, 3, 31 together after reset, then source 1
    tick('0, 1'b1, 1'b1, 1'b0);
    tick(32'h8000_0009, 1'b1, 1'b0, 1'b0);
    tick('0, 1'b1, 1'b0, 1'b0);
    check("rr_first", {24'd0, data_o}, 32'd0);
    tick('0, 1'b1, 1'b0, 1'b0);
    check("rr_second", {24'd0, data_o}, 32'd3);
    tick('0, 1'b1, 1'b0, 1'b0);
    check("rr_third", {24'd0, data_o}, 32'd31);
    tick(32'h0000_0002, 1'b1, 1'b0, 1'b0);
    repeat (3) tick('0, 1'b1, 1'b0, 1'b0);

    // Six sources with consumer stalled, then drained
    tick(32'h0810_1214, 1'b0, 1'b0, 1'b0);
    repeat (7) tick('0, 1'b0, 1'b0, 1'b0);
    check("stall_busy", {31'd0, busy_o}, 32'd1);
    repeat (10) tick('0, 1'b1, 1'b0, 1'b0);

    // Full FIFO, source 7 pulsed twice three cycles apart: one loss pulse
    tick('0, 1'b0, 1'b1, 1'b0);
    tick(32'h0000_3C00, 1'b0, 1'b0, 1'b0);
    repeat (4) tick('0, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_0080, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0, 1'b0);
    tick(32'h0000_0080, 1'b0, 1'b0, 1'b0);
    check("loss_pulse", lost_o, 32'h0000_0080);
    tick('0, 1'b0, 1'b0, 1'b0);
    check("loss_once", lost_o, 32'd0);
`ifdef SOC_EVENT_SENDER_LOSS_CNT_EN
    check("loss_cnt_one", {16'd0, lost_cnt_o}, 32'd1);
    tick('0, 1'b0, 1'b0, 1'b1);
    check("loss_cnt_clr", {16'd0, lost_cnt_o}, 32'd0);
`endif
    // Full FIFO with source 7 pending: push and pop in the same edge
    tick('0, 1'b1, 1'b0, 1'b0);
    check("fullpp_valid", {31'd0, valid_o}, 32'd1);
    repeat (6) tick('0, 1'b1, 1'b0, 1'b0);

    // Reset with 3 queued and 2 pending discards all of them
    tick(32'h0001_1111, 1'b0, 1'b0, 1'b0);
    repeat (3) tick('0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    tick('0, 1'b0, 1'b1, 1'b0);
    check("post_rst_valid", {31'd0, valid_o}, 32'd0);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);
    tick(32'h0000_0400, 1'b1, 1'b0, 1'b0);
    tick('0, 1'b1, 1'b0, 1'b0);
    check("post_rst_id", {24'd0, data_o}, 32'd10);
    tick('0, 1'b1, 1'b0, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      ev = $urandom & $urandom & $urandom;
      tick(ev, $urandom_range(0, 2) != 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
